// File: rtl/mips_pkg.sv
// Shared constants and types for the pipelined MIPS datapath: control-bit
// positions, ALU op codes and the control bundle that travels past EX.
package mips_pkg;

    localparam int CTRL_REG_WRITE  = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_MEM_READ   = 3;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_REG_DST    = 0;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ex_ctrl_t;

    // alu_src and reg_dst are consumed in EX, only the upper four bits go on
    function automatic ex_ctrl_t to_ex_ctrl(input logic [5:0] id_ctrl);
        return ex_ctrl_t'(id_ctrl[CTRL_REG_WRITE:CTRL_MEM_WRITE]);
    endfunction

endpackage

// File: rtl/mips_id_ex_stage_if.sv
// Bus between the decode/forwarding sources and the ID/EX stage; master is the
// surrounding pipeline, slave is the ID/EX stage itself.
interface mips_id_ex_stage_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] id_rd;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [15:0]   id_imm;
    logic [2:0]    id_aluop;
    logic [5:0]    id_ctrl;
    logic          flush;

    logic          exmem_reg_write;
    logic [AW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [AW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;

    logic          stall;
    logic          ex_valid;
    logic [2:0]    Aluop;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] ex_dest;
    logic [3:0]    ex_ctrl;
    logic [DW-1:0] ex_store_data;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_aluop, id_ctrl, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, Aluop, a, b, ex_dest, ex_ctrl, ex_store_data
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
               id_imm, id_aluop, id_ctrl, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, Aluop, a, b, ex_dest, ex_ctrl, ex_store_data
    );
endinterface

// File: rtl/mips_fwd_mux.sv
// Three-way operand selector: EX/MEM result, MEM/WB result or register data.
// EX/MEM is the younger producer so it takes precedence; r0 is never forwarded.
module mips_fwd_mux import mips_pkg::*; #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (exmem_reg_write && (exmem_rd != AW'(REG_ZERO)) && (exmem_rd == src)) begin
            fwd_data = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != AW'(REG_ZERO)) && (memwb_rd == src)) begin
            fwd_data = memwb_result;
        end
    end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion and
// operand forwarding in front of the 32-bit ALU.
module mips_id_ex_stage import mips_pkg::*; #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic               clk,
    input logic               rst_n,
    mips_id_ex_stage_if.slave bus
);

    localparam int EXT = DW - 16;

    logic          ex_valid_q;
    logic [AW-1:0] ex_rs_q;
    logic [AW-1:0] ex_rt_q;
    logic [DW-1:0] ex_rs_data_q;
    logic [DW-1:0] ex_rt_data_q;
    logic [15:0]   ex_imm_q;
    logic [2:0]    aluop_q;
    logic          ex_alu_src_q;
    logic [AW-1:0] ex_dest_q;
    ex_ctrl_t      ex_ctrl_q;

    logic          hazard;
    logic          load_id;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // A load in EX whose destination is read by the ID instruction cannot be forwarded yet
    always_comb begin
        hazard = bus.id_valid & ex_valid_q & ex_ctrl_q.mem_read
               & (ex_dest_q != AW'(REG_ZERO))
               & ((ex_dest_q == bus.id_rs) | (ex_dest_q == bus.id_rt));
    end

    assign bus.stall = hazard & ~bus.flush;
    assign load_id   = bus.id_valid & ~bus.flush & ~hazard;

    // Every non-load case (flush, stall, empty ID) captures an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            aluop_q      <= '0;
            ex_alu_src_q <= 1'b0;
            ex_dest_q    <= '0;
            ex_ctrl_q    <= '0;
        end else if (load_id) begin
            ex_valid_q   <= 1'b1;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_rs_data_q <= bus.id_rs_data;
            ex_rt_data_q <= bus.id_rt_data;
            ex_imm_q     <= bus.id_imm;
            aluop_q      <= bus.id_aluop;
            ex_alu_src_q <= bus.id_ctrl[CTRL_ALU_SRC];
            ex_dest_q    <= bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;
            ex_ctrl_q    <= to_ex_ctrl(bus.id_ctrl);
        end else begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            aluop_q      <= '0;
            ex_alu_src_q <= 1'b0;
            ex_dest_q    <= '0;
            ex_ctrl_q    <= '0;
        end
    end

    mips_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src             (ex_rs_q),
        .reg_data        (ex_rs_data_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_rs)
    );

    mips_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src             (ex_rt_q),
        .reg_data        (ex_rt_data_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd_data        (fwd_rt)
    );

    assign bus.ex_valid      = ex_valid_q;
    assign bus.Aluop         = aluop_q;
    assign bus.ex_dest       = ex_dest_q;
    assign bus.ex_ctrl       = ex_ctrl_q;
    assign bus.a             = fwd_rs;
    assign bus.b             = ex_alu_src_q ? {{EXT{ex_imm_q[15]}}, ex_imm_q} : fwd_rt;
    assign bus.ex_store_data = fwd_rt;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Directed bench for mips_id_ex_stage: expected EX-stage outputs are queued as
// each instruction is driven and popped when it should appear in EX.
module tb_mips_id_ex_stage;
    import mips_pkg::*;

    localparam logic [5:0] C_R  = 6'b100001;
    localparam logic [5:0] C_LW = 6'b111010;
    localparam logic [5:0] C_I  = 6'b100010;

    typedef struct {
        string       tag;
        logic        valid;
        logic [2:0]  aluop;
        logic [4:0]  dest;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sbq[$];

    mips_id_ex_stage_if #(.DW(32), .AW(5)) bus ();

    mips_id_ex_stage #(.DW(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [15:0] imm,
                                 input logic [2:0] op, input logic [5:0] ctrl);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_rs_data = rsd;
        bus.id_rt_data = rtd;
        bus.id_imm     = imm;
        bus.id_aluop   = op;
        bus.id_ctrl    = ctrl;
    endtask

    task automatic setFwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = ew;
        bus.exmem_rd        = erd;
        bus.exmem_result    = eres;
        bus.memwb_reg_write = mw;
        bus.memwb_rd        = mrd;
        bus.memwb_result    = mres;
    endtask

    task automatic pushExp(input string tag, input logic v, input logic [2:0] op,
                           input logic [4:0] dest, input logic [3:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
        exp_t e;
        e.tag = tag; e.valid = v; e.aluop = op; e.dest = dest;
        e.ctrl = ctrl; e.a = a; e.b = b; e.st = st;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = sbq.pop_front();
            cmp({e.tag, "_valid"}, 32'(bus.ex_valid), 32'(e.valid));
            cmp({e.tag, "_aluop"}, 32'(bus.Aluop), 32'(e.aluop));
            cmp({e.tag, "_dest"},  32'(bus.ex_dest), 32'(e.dest));
            cmp({e.tag, "_ctrl"},  32'(bus.ex_ctrl), 32'(e.ctrl));
            cmp({e.tag, "_a"},     bus.a, e.a);
            cmp({e.tag, "_b"},     bus.b, e.b);
            cmp({e.tag, "_store"}, bus.ex_store_data, e.st);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 6'b0);
        setFwd(0, 0, 0, 0, 0, 0);
        #2;
        pushExp("reset", 0, 3'b000, 0, 0, 0, 0, 0);
        checkOutput();
        cmp("reset_stall", 32'(bus.stall), 0);

        // add r3, r1, r2 with r1 forwarded from EX/MEM
        applyStimulus(1, 1, 2, 3, 32'h100, 32'h200, 0, ALU_ADD, C_R);
        setFwd(1, 1, 32'h55, 0, 0, 0);
        #1 rst_n = 1'b1;
        cmp("add_stall", 32'(bus.stall), 0);
        pushExp("exmem_fwd", 1, ALU_ADD, 3, 4'b1000, 32'h55, 32'h200, 32'h200);
        stepClk();

        // and r7, r8, r2 with both stages writing r2
        applyStimulus(1, 8, 2, 7, 32'h800, 32'h222, 0, ALU_AND, C_R);
        setFwd(1, 2, 32'h11, 1, 2, 32'h22);
        pushExp("double_match", 1, ALU_AND, 7, 4'b1000, 32'h800, 32'h11, 32'h11);
        stepClk();
        setFwd(1, 0, 32'h11, 1, 0, 32'h22);
        #1;
        pushExp("zero_rd", 1, ALU_AND, 7, 4'b1000, 32'h800, 32'h222, 32'h222);
        checkOutput();
        setFwd(0, 2, 32'h11, 1, 2, 32'h22);
        #1;
        pushExp("memwb_fwd", 1, ALU_AND, 7, 4'b1000, 32'h800, 32'h22, 32'h22);
        checkOutput();

        // lw r4, 0(r9) followed by sub r5, r4, r6
        setFwd(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 4, 0, 32'h1000, 32'h44, 0, ALU_ADD, C_LW);
        #1 cmp("lw_nostall", 32'(bus.stall), 0);
        pushExp("lw_capture", 1, ALU_ADD, 4, 4'b1110, 32'h1000, 32'h0, 32'h44);
        stepClk();
        applyStimulus(1, 4, 6, 5, 32'hDEAD, 32'h66, 0, ALU_SUB, C_R);
        #1 cmp("loaduse_stall", 32'(bus.stall), 1);
        pushExp("loaduse_bubble", 0, 3'b000, 0, 0, 0, 0, 0);
        stepClk();
        cmp("loaduse_stall_1cyc", 32'(bus.stall), 0);
        setFwd(0, 0, 0, 1, 4, 32'hCAFE);
        pushExp("sub_after_stall", 1, ALU_SUB, 5, 4'b1000, 32'hCAFE, 32'h66, 32'h66);
        stepClk();

        // Immediates of both signs; r0 source with MEM/WB claiming r0
        applyStimulus(1, 0, 10, 0, 32'h0, 32'h1234, 16'hFFF0, ALU_ADD, C_I);
        setFwd(0, 0, 0, 1, 0, 32'h999);
        pushExp("imm_neg", 1, ALU_ADD, 10, 4'b1000, 32'h0, 32'hFFFF_FFF0, 32'h1234);
        stepClk();
        applyStimulus(1, 11, 12, 0, 32'h10, 32'h5, 16'h7FFF, ALU_ADD, C_I);
        setFwd(0, 0, 0, 0, 0, 0);
        pushExp("imm_pos", 1, ALU_ADD, 12, 4'b1000, 32'h10, 32'h0000_7FFF, 32'h5);
        stepClk();

        // Load-use hazard coinciding with a flush
        applyStimulus(1, 1, 13, 0, 32'h20, 32'h0, 16'h4, ALU_ADD, C_LW);
        pushExp("lw2_capture", 1, ALU_ADD, 13, 4'b1110, 32'h20, 32'h4, 32'h0);
        stepClk();
        applyStimulus(1, 13, 2, 14, 32'h300, 32'h2, 0, ALU_OR, C_R);
        #1 cmp("flush_pre_stall", 32'(bus.stall), 1);
        bus.flush = 1'b1;
        #1 cmp("flush_stall", 32'(bus.stall), 0);
        pushExp("flush_bubble", 0, 3'b000, 0, 0, 0, 0, 0);
        stepClk();
        bus.flush = 1'b0;
        #1 cmp("post_flush_stall", 32'(bus.stall), 0);
        pushExp("or_enter", 1, ALU_OR, 14, 4'b1000, 32'h300, 32'h2, 32'h2);
        stepClk();

        applyStimulus(0, 3, 3, 3, 32'hAAAA, 32'hBBBB, 16'h1234, ALU_SLT, C_R);
        pushExp("invalid_bubble", 0, 3'b000, 0, 0, 0, 0, 0);
        stepClk();

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1, 5, 6, 7, 32'h50, 32'h60, 0, ALU_ADD, C_R);
        pushExp("pre_reset", 1, ALU_ADD, 7, 4'b1000, 32'h50, 32'h60, 32'h60);
        stepClk();
        #2 rst_n = 1'b0;
        #1;
        pushExp("async_reset", 0, 3'b000, 0, 0, 0, 0, 0);
        checkOutput();
        cmp("async_reset_stall", 32'(bus.stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pushExp("post_reset_capture", 1, ALU_ADD, 7, 4'b1000, 32'h50, 32'h60, 32'h60);
        stepClk();

        cmp("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_id_ex_stage.md
# mips_id_ex_stage

ID/EX pipeline register and operand-forwarding stage feeding the 32-bit ALU (`mips_ALU_32Bit`) in the pipelined datapath. It captures decoded operands and control from the decode stage and drives the ALU's `a`, `b` and `Aluop`. Its operand sources are register data, the sign-extended immediate, or values forwarded from the EX/MEM and MEM/WB stages. It also detects load-use hazards, raises a stall to the front end, and inserts bubbles on stall or flush.

## Interface
Parameters:
- `DW`, 32, datapath width; must match the ALU.
- `AW`, 5, register-address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_rs`, `id_rt`, `id_rd`  in  AW  source and destination register numbers.
- `id_rs_data`, `id_rt_data`  in  DW  register-file read data.
- `id_imm`  in  16  raw immediate.
- `id_aluop`  in  3  ALU operation code, passed unmodified to `Aluop`.
- `id_ctrl`  in  6  control bits `{reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst}`.
- `flush`  in  1  taken branch or jump; kill the instruction entering EX.
- `exmem_reg_write`  in  1  EX/MEM stage will write `exmem_rd`.
- `exmem_rd`  in  AW  EX/MEM destination register.
- `exmem_result`  in  DW  EX/MEM forwarded value.
- `memwb_reg_write`  in  1  MEM/WB stage will write `memwb_rd`.
- `memwb_rd`  in  AW  MEM/WB destination register.
- `memwb_result`  in  DW  MEM/WB forwarded value.
- `stall`  out  1  hold the PC and IF/ID register this cycle.
- `ex_valid`  out  1  the EX-stage instruction is real.
- `Aluop`  out  3  to the ALU.
- `a`  out  DW  to the ALU.
- `b`  out  DW  to the ALU.
- `ex_dest`  out  AW  resolved destination register.
- `ex_ctrl`  out  4  `{reg_write, mem_to_reg, mem_read, mem_write}` passed to EX/MEM.
- `ex_store_data`  out  DW  forwarded rt value, used for stores.

## Operation
- **EX register contents:** `ex_valid`, `ex_rs`, `ex_rt`, `ex_rs_data`, `ex_rt_data`, `ex_imm`, `Aluop`, `ex_alu_src`, `ex_dest`, `ex_ctrl`.
- **`ex_dest` resolution:** `ex_dest` is resolved at capture as `reg_dst ? id_rd : id_rt`.
- **Hazard detection (combinational):**
  - `hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt)`.
  - `stall = hazard & ~flush`.
- **Capture rule, per rising edge, in priority order:**
  1. `flush` → bubble.
  2. `stall` → bubble.
  3. `id_valid = 0` → bubble.
  4. Otherwise, load all ID fields.
- **Bubble definition:** `ex_valid = 0`, `ex_ctrl = 0`, `Aluop = 000`. All other fields are loaded as zero.
- **Forwarding (combinational), applied separately to rs and rt:**
  - If `exmem_reg_write & exmem_rd != 0 & exmem_rd == src`, use `exmem_result`.
  - Else if `memwb_reg_write & memwb_rd != 0 & memwb_rd == src`, use `memwb_result`.
  - Else use the registered data.
  - EX/MEM wins when both stages match.
  - Register 0 is never forwarded.
- **Operand outputs:**
  - `a = fwd_rs`.
  - `b = ex_alu_src ? {{16{ex_imm[15]}}, ex_imm} : fwd_rt`.
  - `ex_store_data = fwd_rt`.
- **Forwarding is independent of `ex_valid`:** forwarding is not gated by `ex_valid`. In a bubble all fields are zero, so no forward can fire.

## Timing
- **Reset values:** all registered fields are 0, which gives `ex_valid = 0`, `Aluop = 000`, `ex_dest = 0` and `ex_ctrl = 0`. Consequently `a = 0`, `b = 0`, `ex_store_data = 0` and `stall = 0`.
- **Reset mid-operation:** asserting `rst_n = 0` clears the instruction in EX immediately (asynchronously). Release is synchronous to the next edge.
- **Latency:** one cycle from ID inputs to the EX registers. `a`, `b` and `ex_store_data` follow `exmem_*`/`memwb_*` in the same cycle with no register.
- **Stall length:** a load-use stall lasts exactly one cycle. The bubble clears `ex_valid`, so `hazard` drops the next cycle and the held instruction then enters EX with the loaded value available via MEM/WB forwarding.
- **Simultaneous stall and flush:** `flush` wins; `stall` is 0 and a bubble is inserted.
- **Upstream contract:** upstream must hold its ID inputs stable while `stall = 1`.

## Structure
- **Shared package `mips_pkg`:**
  - `id_ctrl` bit-index constants.
  - ALU op constants: `ALU_AND = 000`, `ALU_OR = 001`, `ALU_ADD = 010`, `ALU_SUB = 110`, `ALU_SLT = 111`.
  - `REG_ZERO = 0`.
- **Sub-module `mips_fwd_mux`:** one 3-way forwarding selector, instantiated twice (rs and rt).

## Test plan
- **Reset:** assert `rst_n = 0` mid-run → all outputs 0 immediately; after release, the first valid ID instruction appears in EX after one edge.
- **EX/MEM forwarding:** `add r3, r1, r2` in EX with `exmem_rd = 1`, `exmem_result = 0x0000_0055`, `exmem_reg_write = 1` → `a = 0x55`, independent of `ex_rs_data`.
- **Double match:** `exmem_rd = memwb_rd = 2` with results `0x11` and `0x22`, instruction using `rt = 2` → `b = 0x11`. The same case with `exmem_rd = 0` and `memwb_rd = 0` → `b = ex_rt_data`.
- **Load-use:** `lw r4` in EX, ID instruction `sub r5, r4, r6` → `stall = 1` for exactly one cycle, then a bubble (`ex_valid = 0`, `Aluop = 000`), then `sub` in EX with `a = memwb_result`.
- **Immediate:** `alu_src = 1`, `id_imm = 0xFFF0` → `b = 0xFFFF_FFF0`; `id_imm = 0x7FFF` → `b = 0x0000_7FFF`.
- **Stall plus flush:** load-use hazard with `flush = 1` in the same cycle → `stall = 0`, bubble captured, `ex_ctrl = 0`.
